proj_lif_mem_ctrl: RTL and testbench
====================================

Name: proj_lif_mem_ctrl

Overview:
- Membrane-state controller that sits directly upstream of proj_lif.
- Accepts per-neuron delta-membrane values from the projection accumulator, in neuron order, for TIME_STEPS timesteps.
- Reads each neuron's previous membrane from an internal RAM and presents the aligned delta/pre_mem pair to proj_lif.
- Writes proj_lif's next membrane back to the RAM and packs the returned spikes into SPIKE_W-bit words for the downstream spike buffer.

Parameters:
ADD9_ALL_BITS, `ADD9_ALL_BITS, membrane/delta width (signed two's complement)
NEURON_NUM, 512, neurons per timestep; must be >= 4
TIME_STEPS, 4, timesteps per inference
SPIKE_W, 32, bits per packed spike word

Ports:
s_clk  in  1  clock
s_rst_n  in  1  synchronous active-low reset
i_start  in  1  one-cycle pulse; begins an inference
i_delta_mem  in  ADD9_ALL_BITS  delta membrane for the current neuron
i_delta_mem_valid  in  1  delta valid
o_delta_mem_ready  out  1  block accepts delta this cycle
o_lif_delta_mem  out  ADD9_ALL_BITS  to proj_lif i_delta_mem
o_lif_delta_valid  out  1  to proj_lif i_delta_mem_valid
o_lif_pre_mem  out  ADD9_ALL_BITS  to proj_lif i_pre_mem
i_lif_spike  in  1  from proj_lif o_spike
i_lif_valid  in  1  from proj_lif o_delta_mem_valid
i_lif_nxt_mem  in  ADD9_ALL_BITS  from proj_lif o_nxt_mem
o_spike_word  out  SPIKE_W  packed spikes; bit 0 = lowest neuron index in the word
o_spike_valid  out  1  one-cycle word strobe
o_spike_tstep  out  clog2(TIME_STEPS)  timestep of o_spike_word
o_busy  out  1  high in RUN or DRAIN
o_done  out  1  one-cycle pulse at inference end

Behaviour:
- Reset (s_rst_n=0 at a clock edge): every output is 0, FSM is IDLE, all counters are 0. RAM contents are don't-care.
- Reset mid-operation aborts the inference: no o_done, no further spike words.
- FSM:
  - IDLE -> RUN on i_start.
  - RUN -> DRAIN when the last delta is accepted (neuron NEURON_NUM-1 of timestep TIME_STEPS-1).
  - DRAIN -> DONE when the write-side counters reach that same neuron/timestep.
  - DONE -> IDLE after one cycle; o_done=1 only in DONE.
  - i_start outside IDLE is ignored.
- o_delta_mem_ready = (state==RUN). An accept is valid && ready; deltas arriving in IDLE/DRAIN/DONE are dropped.
- Read side:
  - Accept at cycle k issues a RAM read at the read neuron counter rd_n.
  - rd_n wraps at NEURON_NUM-1; on wrap, rd_t increments.
- LIF drive, cycle k+1:
  - o_lif_delta_mem = registered delta; o_lif_delta_valid = 1.
  - o_lif_pre_mem = RAM data, forced to 0 when rd_t was 0 (no RAM clearing needed between inferences).
  - o_lif_delta_valid is 0 on every other cycle.
- Write side, cycle k+2 (i_lif_valid=1):
  - RAM[wr_n] <= i_lif_nxt_mem.
  - i_lif_spike is shifted into the packer at bit position wr_n mod SPIKE_W.
  - wr_n/wr_t wrap like rd_n/rd_t.
- Hazard: a read and a write to the same address are at least NEURON_NUM-2 cycles apart, so no bypass is needed; NEURON_NUM>=4 is required.
- Packer output:
  - o_spike_valid pulses the cycle after the bit for wr_n mod SPIKE_W == SPIKE_W-1 is captured, and also after wr_n == NEURON_NUM-1.
  - A partial final word has its upper unused bits zero.
  - o_spike_word and o_spike_tstep are held until the next strobe.
  - The packer clears after each strobe.
- Gaps: valid may drop at any time; the pipeline simply carries bubbles and all counters advance only on accept / i_lif_valid.
- Bubbles during DRAIN are fine; the last spike word strobes no later than the cycle o_done pulses.
- Simultaneous events:
  - i_start with i_delta_mem_valid in IDLE: the delta is dropped (ready=0 that cycle).
  - Read and write in the same cycle (different addresses) are both serviced; the RAM is simple dual-port.

Test Plan (NEURON_NUM=8, SPIKE_W=4, TIME_STEPS=2, proj_lif attached, THRESHOLD=16):
- Basic t0: i_start, then deltas 40,10,0,0,0,0,0,0 back-to-back.
  - Required: o_lif_pre_mem=0 for all eight.
  - Required: word0=4'b0001 at tstep 0, word1=4'b0000.
  - Required: RAM[1]=5, RAM[0]=0.
- Accumulate t1: continuing the same inference, deltas 30,30,0,… -> o_lif_pre_mem for neuron1 = 5; (30+5)>>>1=17 spikes; neuron0 gives 15, no spike. word0=4'b0010 at tstep 1; o_done pulses once after the final word; o_busy drops with o_done.
- Latency check: a single delta accepted at cycle k -> o_lif_delta_valid exactly at k+1; the RAM write is visible to the next timestep's read of that neuron.
- Bubbles: valid toggled 1-0-1-0 through both timesteps -> spike words and stored membranes are identical to the back-to-back run; o_delta_mem_ready stays 1 throughout RUN.
- Idle/abuse:
  - Deltas while IDLE -> o_delta_mem_ready=0, no o_lif_delta_valid.
  - i_start during RUN -> counters unaffected.
- Reset mid-run: s_rst_n low during t1 -> next cycle all outputs 0, no o_done. A new i_start then reproduces the t0 results with pre_mem=0.

Source files
------------

// File: rtl/proj_lif_mem_ctrl.sv
// proj_lif_mem_ctrl: membrane-state controller in front of proj_lif.
// Takes per-neuron delta membranes in neuron order for TIME_STEPS timesteps.
// Looks up each neuron's previous membrane in an internal simple dual-port RAM
// and presents the aligned delta/pre_mem pair to proj_lif. Writes proj_lif's
// next membrane back and packs the returned spikes into SPIKE_W-bit words.
// Ports:
//   s_clk, s_rst_n                 clock, synchronous active-low reset
//   i_start                        begins an inference (IDLE only)
//   i_delta_mem/_valid, o_delta_mem_ready   delta input handshake
//   o_lif_delta_mem/_valid, o_lif_pre_mem   drive to proj_lif
//   i_lif_spike/_valid, i_lif_nxt_mem       return from proj_lif
//   o_spike_word/_valid/_tstep     packed spike words
//   o_busy, o_done                 status
`ifndef ADD9_ALL_BITS
`define ADD9_ALL_BITS 16
`endif

module proj_lif_mem_ctrl #(
  parameter int unsigned ADD9_ALL_BITS = `ADD9_ALL_BITS,
  parameter int unsigned NEURON_NUM    = 512,
  parameter int unsigned TIME_STEPS    = 4,
  parameter int unsigned SPIKE_W       = 32,
  localparam int unsigned TW = (TIME_STEPS > 1) ? $clog2(TIME_STEPS) : 1
) (
  input  logic                     s_clk,
  input  logic                     s_rst_n,
  input  logic                     i_start,
  input  logic [ADD9_ALL_BITS-1:0] i_delta_mem,
  input  logic                     i_delta_mem_valid,
  output logic                     o_delta_mem_ready,
  output logic [ADD9_ALL_BITS-1:0] o_lif_delta_mem,
  output logic                     o_lif_delta_valid,
  output logic [ADD9_ALL_BITS-1:0] o_lif_pre_mem,
  input  logic                     i_lif_spike,
  input  logic                     i_lif_valid,
  input  logic [ADD9_ALL_BITS-1:0] i_lif_nxt_mem,
  output logic [SPIKE_W-1:0]       o_spike_word,
  output logic                     o_spike_valid,
  output logic [TW-1:0]            o_spike_tstep,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned NW = $clog2(NEURON_NUM);
  localparam int unsigned PW = (SPIKE_W > 1) ? $clog2(SPIKE_W) : 1;
  localparam logic [NW-1:0] N_LAST = NW'(NEURON_NUM - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIME_STEPS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(SPIKE_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [NW-1:0]            rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic [TW-1:0]            rd_t_q, rd_t_d, wr_t_q, wr_t_d;
  logic [SPIKE_W-1:0]       pack_q, pack_d, word_q, word_d;
  logic [PW-1:0]            pidx_q, pidx_d;
  logic [TW-1:0]            tstep_q, tstep_d;
  logic                     svalid_q, svalid_d;
  logic [ADD9_ALL_BITS-1:0] delta_q, delta_d;
  logic                     lvalid_q, lvalid_d;
  logic                     pre_zero_q, pre_zero_d;
  logic                     ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [ADD9_ALL_BITS-1:0] rd_data_q;
  logic [ADD9_ALL_BITS-1:0] mem [NEURON_NUM];

  logic                     accept, wr_en;
  logic [SPIKE_W-1:0]       pack_bit;

  // Next-state, counters, packer and LIF drive
  always_comb begin
    state_d    = state_q;
    rd_n_d     = rd_n_q;
    rd_t_d     = rd_t_q;
    wr_n_d     = wr_n_q;
    wr_t_d     = wr_t_q;
    pack_d     = pack_q;
    pidx_d     = pidx_q;
    word_d     = word_q;
    tstep_d    = tstep_q;
    svalid_d   = 1'b0;
    delta_d    = delta_q;
    lvalid_d   = 1'b0;
    pre_zero_d = pre_zero_q;
    accept     = i_delta_mem_valid && (state_q == RUN);
    // returns outside an inference (e.g. after an abort) are discarded
    wr_en      = i_lif_valid && ((state_q == RUN) || (state_q == DRAIN));
    pack_bit   = SPIKE_W'(i_lif_spike) << pidx_q;

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          rd_n_d  = '0;
          rd_t_d  = '0;
          wr_n_d  = '0;
          wr_t_d  = '0;
          pack_d  = '0;
          pidx_d  = '0;
        end
      end
      RUN:     if (accept && (rd_n_q == N_LAST) && (rd_t_q == T_LAST)) state_d = DRAIN;
      DRAIN:   if (wr_en && (wr_n_q == N_LAST) && (wr_t_q == T_LAST)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      delta_d    = i_delta_mem;
      lvalid_d   = 1'b1;
      // first timestep starts from rest, so stale RAM never needs clearing
      pre_zero_d = (rd_t_q == '0);
      if (rd_n_q == N_LAST) begin
        rd_n_d = '0;
        rd_t_d = (rd_t_q == T_LAST) ? '0 : rd_t_q + TW'(1);
      end else begin
        rd_n_d = rd_n_q + NW'(1);
      end
    end

    if (wr_en) begin
      if (wr_n_q == N_LAST) begin
        wr_n_d = '0;
        wr_t_d = (wr_t_q == T_LAST) ? '0 : wr_t_q + TW'(1);
      end else begin
        wr_n_d = wr_n_q + NW'(1);
      end
      // flush on a full word or at the end of the timestep's neurons
      if ((pidx_q == P_LAST) || (wr_n_q == N_LAST)) begin
        word_d   = pack_q | pack_bit;
        tstep_d  = wr_t_q;
        svalid_d = 1'b1;
        pack_d   = '0;
        pidx_d   = '0;
      end else begin
        pack_d = pack_q | pack_bit;
        pidx_d = pidx_q + PW'(1);
      end
    end

    ready_d = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
  end

  // Control and output registers
  always_ff @(posedge s_clk) begin
    if (!s_rst_n) begin
      state_q    <= IDLE;
      rd_n_q     <= '0;
      rd_t_q     <= '0;
      wr_n_q     <= '0;
      wr_t_q     <= '0;
      pack_q     <= '0;
      pidx_q     <= '0;
      word_q     <= '0;
      tstep_q    <= '0;
      svalid_q   <= 1'b0;
      delta_q    <= '0;
      lvalid_q   <= 1'b0;
      pre_zero_q <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_n_q     <= rd_n_d;
      rd_t_q     <= rd_t_d;
      wr_n_q     <= wr_n_d;
      wr_t_q     <= wr_t_d;
      pack_q     <= pack_d;
      pidx_q     <= pidx_d;
      word_q     <= word_d;
      tstep_q    <= tstep_d;
      svalid_q   <= svalid_d;
      delta_q    <= delta_d;
      lvalid_q   <= lvalid_d;
      pre_zero_q <= pre_zero_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Membrane RAM: one write port (LIF return) and one registered read port
  always_ff @(posedge s_clk) begin
    if (wr_en)  mem[wr_n_q] <= i_lif_nxt_mem;
    if (accept) rd_data_q   <= mem[rd_n_q];
  end

  assign o_delta_mem_ready = ready_q;
  assign o_lif_delta_mem   = delta_q;
  assign o_lif_delta_valid = lvalid_q;
  assign o_lif_pre_mem     = pre_zero_q ? '0 : rd_data_q;
  assign o_spike_word      = word_q;
  assign o_spike_valid     = svalid_q;
  assign o_spike_tstep     = tstep_q;
  assign o_busy            = busy_q;
  assign o_done            = done_q;

endmodule

// File: tb/tb_proj_lif_mem_ctrl.sv
// tb_proj_lif_mem_ctrl: directed bench for proj_lif_mem_ctrl with a small
// proj_lif model attached (mem = (delta + pre) >>> 1, spike and reset to 0
// when mem > THRESHOLD, one-cycle latency).
module tb_proj_lif_mem_ctrl;
  localparam int unsigned W  = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned T  = 2;
  localparam int unsigned SW = 4;
  localparam int THRESH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  delta = '0;
  logic          dv = 1'b0;
  logic          ready, lif_dv, lif_spike, lif_valid, spk_valid, busy, done;
  logic [W-1:0]  lif_delta, lif_pre, lif_nxt;
  logic [SW-1:0] spk_word;
  logic [0:0]    spk_tstep;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] words[$];

  always #5 clk = ~clk;

  proj_lif_mem_ctrl #(.ADD9_ALL_BITS(W), .NEURON_NUM(N), .TIME_STEPS(T), .SPIKE_W(SW)) dut (
    .s_clk(clk), .s_rst_n(rst_n), .i_start(start),
    .i_delta_mem(delta), .i_delta_mem_valid(dv), .o_delta_mem_ready(ready),
    .o_lif_delta_mem(lif_delta), .o_lif_delta_valid(lif_dv), .o_lif_pre_mem(lif_pre),
    .i_lif_spike(lif_spike), .i_lif_valid(lif_valid), .i_lif_nxt_mem(lif_nxt),
    .o_spike_word(spk_word), .o_spike_valid(spk_valid), .o_spike_tstep(spk_tstep),
    .o_busy(busy), .o_done(done)
  );

  // proj_lif model
  logic signed [W:0] sum_c;
  always_comb sum_c = ($signed({lif_delta[W-1], lif_delta}) + $signed({lif_pre[W-1], lif_pre})) >>> 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lif_valid <= 1'b0;
      lif_spike <= 1'b0;
      lif_nxt   <= '0;
    end else begin
      lif_valid <= lif_dv;
      lif_spike <= lif_dv && (sum_c > THRESH);
      lif_nxt   <= (sum_c > THRESH) ? '0 : sum_c[W-1:0];
    end
  end

  // spike word / done monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (spk_valid) words.push_back({3'b000, spk_tstep, spk_word});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_lif_dv"}, 32'(lif_dv), 0);
    chk({tag, "_lif_delta"}, 32'(lif_delta), 0);
    chk({tag, "_lif_pre"}, 32'(lif_pre), 0);
    chk({tag, "_spk_word"}, 32'(spk_word), 0);
    chk({tag, "_spk_valid"}, 32'(spk_valid), 0);
    chk({tag, "_spk_tstep"}, 32'(spk_tstep), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
  endtask

  task automatic begin_inf();
    start = 1'b1; dv = 1'b1; delta = W'(99);
    chk("ready_at_start", 32'(ready), 0);
    tick();
    start = 1'b0; dv = 1'b0;
    chk("busy_run", 32'(busy), 1);
    chk("no_lif_on_start", 32'(lif_dv), 0);
    chk("ready_run", 32'(ready), 1);
  endtask

  // one accept at cycle k, LIF drive checked at k+1
  task automatic send(input int d, input int exp_pre, input bit st);
    delta = W'(d); dv = 1'b1; start = st;
    chk("ready_accept", 32'(ready), 1);
    tick();
    dv = 1'b0; start = 1'b0;
    chk("lif_valid", 32'(lif_dv), 1);
    chk("lif_delta", 32'(lif_delta), 32'(d));
    chk("lif_pre", 32'(lif_pre), 32'(exp_pre));
  endtask

  task automatic bubble();
    tick();
    chk("bubble_lif_valid", 32'(lif_dv), 0);
    chk("bubble_ready", 32'(ready), 1);
  endtask

  int d0[N] = '{40, 10, 0, 0, 0, 0, 0, 0};
  int d1[N] = '{30, 30, 0, 0, 0, 0, 0, 0};
  int p1[N] = '{0, 5, 0, 0, 0, 0, 0, 0};
  logic [7:0] exp_words[4] = '{8'h01, 8'h00, 8'h12, 8'h10};

  task automatic run_inf(input bit bubbles, input bit poke);
    bit got;
    words.delete();
    done_cnt = 0;
    begin_inf();
    for (int n = 0; n < int'(N); n++) begin
      send(d0[n], 0, poke && (n == 3));
      if (bubbles) bubble();
    end
    for (int n = 0; n < int'(N); n++) begin
      send(d1[n], p1[n], poke && (n == 2));
      if (bubbles && (n != int'(N) - 1)) bubble();
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else tick();
    end
    chk("done_seen", 32'(got), 1);
    chk("busy_at_done", 32'(busy), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("word_count_by_done", 32'(words.size()), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("word%0d", i), 32'((i < words.size()) ? words[i] : 8'hFF), 32'(exp_words[i]));
    repeat (4) tick();
    chk("done_pulses", 32'(done_cnt), 1);
    chk("word_held", 32'(spk_word), 0);
    chk("tstep_held", 32'(spk_tstep), 1);
    chk("ram0_final", 32'(dut.mem[0]), 15);
    chk("ram1_final", 32'(dut.mem[1]), 0);
    chk("idle_ready", 32'(ready), 0);
  endtask

  initial begin
    int nw;
    rst_n = 1'b0;
    repeat (2) tick();
    chk_zero("reset");
    rst_n = 1'b1;

    // deltas while idle are dropped
    dv = 1'b1; delta = W'(40);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_ready", 32'(ready), 0);
      chk("idle_lif_dv", 32'(lif_dv), 0);
      chk("idle_busy", 32'(busy), 0);
    end
    dv = 1'b0;

    run_inf(1'b0, 1'b1);   // back-to-back, with ignored i_start pulses
    run_inf(1'b1, 1'b0);   // 1-0-1-0 valid pattern

    // abort during the second timestep
    words.delete();
    begin_inf();
    for (int n = 0; n < int'(N); n++) send(d0[n], 0, 1'b0);
    send(d1[0], p1[0], 1'b0);
    send(d1[1], p1[1], 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_zero("abort");
    done_cnt = 0;
    nw = words.size();
    repeat (10) tick();
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_no_words", 32'(words.size()), 32'(nw));

    run_inf(1'b0, 1'b0);   // fresh inference after abort

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
